// File: rtl/periph_xbar_credit.sv
// Peripheral crossbar: N_INPS masters to N_OUPS slaves with round-robin arbitration
// per output, credit-based admission, per-input target ordering and per-input
// response FIFOs with backpressure. The target index arrives pre-decoded on in_sel_i.
module periph_xbar_credit #(
  parameter int unsigned N_INPS     = 9,
  parameter int unsigned N_OUPS     = 10,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BE_WIDTH   = 4,
  parameter int unsigned RSP_DEPTH  = 2,
  localparam int unsigned SEL_W = $clog2(N_OUPS),
  localparam int unsigned ID_W  = (N_INPS > 1) ? $clog2(N_INPS) : 1,
  localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [N_INPS-1:0]            in_req_i,
  input  logic [N_INPS*SEL_W-1:0]      in_sel_i,
  input  logic [N_INPS*ADDR_WIDTH-1:0] in_addr_i,
  input  logic [N_INPS*DATA_WIDTH-1:0] in_wdata_i,
  input  logic [N_INPS-1:0]            in_wen_i,
  input  logic [N_INPS*BE_WIDTH-1:0]   in_be_i,
  output logic [N_INPS-1:0]            in_gnt_o,
  output logic [N_INPS-1:0]            in_rvalid_o,
  output logic [N_INPS*DATA_WIDTH-1:0] in_rdata_o,
  output logic [N_INPS-1:0]            in_ropc_o,
  input  logic [N_INPS-1:0]            in_rready_i,
  output logic [N_OUPS-1:0]            out_req_o,
  output logic [N_OUPS*ADDR_WIDTH-1:0] out_addr_o,
  output logic [N_OUPS*DATA_WIDTH-1:0] out_wdata_o,
  output logic [N_OUPS-1:0]            out_wen_o,
  output logic [N_OUPS*BE_WIDTH-1:0]   out_be_o,
  output logic [N_OUPS*ID_W-1:0]       out_id_o,
  input  logic [N_OUPS-1:0]            out_gnt_i,
  input  logic [N_OUPS-1:0]            out_rvalid_i,
  input  logic [N_OUPS*DATA_WIDTH-1:0] out_rdata_i,
  input  logic [N_OUPS-1:0]            out_ropc_i,
  input  logic [N_OUPS*ID_W-1:0]       out_rid_i,
  output logic                         err_o
);

  localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned RSP_W = DATA_WIDTH + 1;

  // state
  logic [CNT_W-1:0] cnt_q      [N_INPS];
  logic [SEL_W-1:0] last_sel_q [N_INPS];
  logic [ID_W-1:0]  rr_ptr_q   [N_OUPS];
  logic [RSP_W-1:0] fifo_mem_q [N_INPS][RSP_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q   [N_INPS];
  logic [PTR_W-1:0] wr_ptr_q   [N_INPS];
  logic [CNT_W-1:0] fill_q     [N_INPS];
  logic             err_q;

  // combinational helpers
  logic [SEL_W-1:0]      sel     [N_INPS];
  logic [ADDR_WIDTH-1:0] addr_a  [N_INPS];
  logic [DATA_WIDTH-1:0] wdata_a [N_INPS];
  logic [BE_WIDTH-1:0]   be_a    [N_INPS];
  logic [N_INPS-1:0]     elig;
  logic [N_OUPS-1:0]     win_vld;
  logic [ID_W-1:0]       win_idx [N_OUPS];
  logic [N_INPS-1:0]     push, multi, pop, full, accept, ovf;
  logic [RSP_W-1:0]      push_data [N_INPS];
  logic                  rid_err;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (32'(p) == RSP_DEPTH - 1) ? '0 : p + PTR_W'(1);
  endfunction

  // Unpack request fields and decide per-input eligibility (credits + target ordering)
  always_comb begin
    elig = '0;
    for (int i = 0; i < int'(N_INPS); i++) begin
      sel[i]     = in_sel_i[i*SEL_W +: SEL_W];
      addr_a[i]  = in_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
      wdata_a[i] = in_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
      be_a[i]    = in_be_i[i*BE_WIDTH +: BE_WIDTH];
      elig[i]    = in_req_i[i] && (32'(sel[i]) < N_OUPS) && (32'(cnt_q[i]) < RSP_DEPTH) &&
                   ((cnt_q[i] == '0) || (sel[i] == last_sel_q[i]));
    end
  end

  // Round-robin winner per output, search starting at rr_ptr
  always_comb begin
    int unsigned     sum;
    logic [ID_W-1:0] idx;
    sum     = 0;
    idx     = '0;
    win_vld = '0;
    for (int o = 0; o < int'(N_OUPS); o++) begin
      win_idx[o] = '0;
      for (int k = 0; k < int'(N_INPS); k++) begin
        sum = 32'(rr_ptr_q[o]) + 32'(k);
        if (sum >= N_INPS) sum = sum - N_INPS;
        idx = ID_W'(sum);
        if (!win_vld[o] && elig[idx] && (32'(sel[idx]) == 32'(o))) begin
          win_vld[o] = 1'b1;
          win_idx[o] = idx;
        end
      end
    end
  end

  // Forward winner fields to each output and route the slave grant back
  always_comb begin
    out_req_o   = win_vld;
    out_addr_o  = '0;
    out_wdata_o = '0;
    out_wen_o   = '0;
    out_be_o    = '0;
    out_id_o    = '0;
    in_gnt_o    = '0;
    for (int o = 0; o < int'(N_OUPS); o++) begin
      out_id_o[o*ID_W +: ID_W] = win_idx[o];
      if (win_vld[o]) begin
        out_addr_o[o*ADDR_WIDTH +: ADDR_WIDTH] = addr_a[win_idx[o]];
        out_wdata_o[o*DATA_WIDTH +: DATA_WIDTH] = wdata_a[win_idx[o]];
        out_wen_o[o] = in_wen_i[win_idx[o]];
        out_be_o[o*BE_WIDTH +: BE_WIDTH] = be_a[win_idx[o]];
        if (out_gnt_i[o]) in_gnt_o[win_idx[o]] = 1'b1;
      end
    end
  end

  // Route slave responses to input FIFOs; lowest output wins a collision
  always_comb begin
    logic [ID_W-1:0] rid;
    rid     = '0;
    push    = '0;
    multi   = '0;
    rid_err = 1'b0;
    for (int i = 0; i < int'(N_INPS); i++) push_data[i] = '0;
    for (int o = 0; o < int'(N_OUPS); o++) begin
      rid = out_rid_i[o*ID_W +: ID_W];
      if (out_rvalid_i[o]) begin
        if (32'(rid) >= N_INPS) begin
          rid_err = 1'b1;
        end else if (push[rid]) begin
          multi[rid] = 1'b1;
        end else begin
          push[rid]      = 1'b1;
          push_data[rid] = {out_rdata_i[o*DATA_WIDTH +: DATA_WIDTH], out_ropc_i[o]};
        end
      end
    end
  end

  // FIFO handshake and overflow detection; a pop frees a slot for a same-cycle push
  always_comb begin
    for (int i = 0; i < int'(N_INPS); i++) begin
      in_rvalid_o[i] = (fill_q[i] != '0);
      pop[i]         = in_rvalid_o[i] && in_rready_i[i];
      full[i]        = (32'(fill_q[i]) == RSP_DEPTH);
      accept[i]      = push[i] && (!full[i] || pop[i]);
      ovf[i]         = push[i] && full[i] && !pop[i];
      in_rdata_o[i*DATA_WIDTH +: DATA_WIDTH] = fifo_mem_q[i][rd_ptr_q[i]][RSP_W-1:1];
      in_ropc_o[i]   = fifo_mem_q[i][rd_ptr_q[i]][0];
    end
  end

  assign err_o = err_q;

  // Control state: credits, ordering, FIFO pointers, arbitration pointers, sticky error
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(N_INPS); i++) begin
        cnt_q[i]      <= '0;
        last_sel_q[i] <= '0;
        rd_ptr_q[i]   <= '0;
        wr_ptr_q[i]   <= '0;
        fill_q[i]     <= '0;
      end
      for (int o = 0; o < int'(N_OUPS); o++) rr_ptr_q[o] <= '0;
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < int'(N_INPS); i++) begin
        if (in_gnt_o[i] && !pop[i]) begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end else if (!in_gnt_o[i] && pop[i] && (cnt_q[i] != '0)) begin
          cnt_q[i] <= cnt_q[i] - CNT_W'(1);
        end
        if (in_gnt_o[i]) last_sel_q[i] <= sel[i];
        if (accept[i]) wr_ptr_q[i] <= ptr_inc(wr_ptr_q[i]);
        if (pop[i])    rd_ptr_q[i] <= ptr_inc(rd_ptr_q[i]);
        if (accept[i] && !pop[i]) begin
          fill_q[i] <= fill_q[i] + CNT_W'(1);
        end else if (!accept[i] && pop[i]) begin
          fill_q[i] <= fill_q[i] - CNT_W'(1);
        end
      end
      for (int o = 0; o < int'(N_OUPS); o++) begin
        if (win_vld[o] && out_gnt_i[o]) begin
          rr_ptr_q[o] <= (32'(win_idx[o]) == N_INPS - 1) ? '0 : win_idx[o] + ID_W'(1);
        end
      end
      err_q <= err_q || rid_err || (|multi) || (|ovf);
    end
  end

  // Response storage, written on accepted pushes only
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < int'(N_INPS); i++) begin
      if (accept[i]) fifo_mem_q[i][wr_ptr_q[i]] <= push_data[i];
    end
  end

endmodule

// File: tb/tb_periph_xbar_credit.sv
// Bench for periph_xbar_credit: 3 masters, 4 slaves, 2 credits. A bus process models
// masters and slaves; a scoreboard queues the expected response per input at grant time.
module tb_periph_xbar_credit;

  localparam int unsigned NI = 3;
  localparam int unsigned NO = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;
  localparam int unsigned RD = 2;
  localparam int unsigned SW = 2;
  localparam int unsigned IW = 2;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic [NI-1:0]    in_req_i, in_wen_i, in_gnt_o, in_rvalid_o, in_ropc_o, in_rready_i;
  logic [NI*SW-1:0] in_sel_i;
  logic [NI*AW-1:0] in_addr_i;
  logic [NI*DW-1:0] in_wdata_i, in_rdata_o;
  logic [NI*BW-1:0] in_be_i;
  logic [NO-1:0]    out_req_o, out_wen_o, out_gnt_i, out_rvalid_i, out_ropc_i;
  logic [NO*AW-1:0] out_addr_o;
  logic [NO*DW-1:0] out_wdata_o, out_rdata_i;
  logic [NO*BW-1:0] out_be_o;
  logic [NO*IW-1:0] out_id_o, out_rid_i;
  logic             err_o;

  always #5 clk_i = ~clk_i;

  periph_xbar_credit #(
    .N_INPS(NI), .N_OUPS(NO), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .RSP_DEPTH(RD)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .in_req_i(in_req_i), .in_sel_i(in_sel_i), .in_addr_i(in_addr_i), .in_wdata_i(in_wdata_i),
    .in_wen_i(in_wen_i), .in_be_i(in_be_i), .in_gnt_o(in_gnt_o), .in_rvalid_o(in_rvalid_o),
    .in_rdata_o(in_rdata_o), .in_ropc_o(in_ropc_o), .in_rready_i(in_rready_i),
    .out_req_o(out_req_o), .out_addr_o(out_addr_o), .out_wdata_o(out_wdata_o),
    .out_wen_o(out_wen_o), .out_be_o(out_be_o), .out_id_o(out_id_o), .out_gnt_i(out_gnt_i),
    .out_rvalid_i(out_rvalid_i), .out_rdata_i(out_rdata_i), .out_ropc_i(out_ropc_i),
    .out_rid_i(out_rid_i), .err_o(err_o)
  );

  typedef struct packed {
    logic [31:0]  due;
    logic [DW:0]  rsp;
    logic [IW-1:0] id;
  } sl_t;

  sl_t         sq    [NO][$];
  logic [DW:0] exp_q [NI][$];
  sl_t         ent;
  int          left  [NI];
  int          seq   [NI];
  int          msel  [NI];
  bit          got_gnt [NI];
  int unsigned dly   [NO];
  logic [NI-1:0] rready_cfg;
  bit          force_bad;
  int unsigned cyc;
  int          n_chk, n_pass;

  function automatic logic [AW-1:0] mk_addr(input int i, input int s, input int q);
    return {8'(i), 8'(s), 16'(q)};
  endfunction

  // Slave response payload derived from the address it was asked for
  function automatic logic [DW:0] rsp_of(input logic [AW-1:0] a);
    return {~{a[15:0], a[31:16]}, a[1]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic int pending();
    int p = 0;
    for (int i = 0; i < int'(NI); i++) p += left[i] - int'(got_gnt[i]) + exp_q[i].size();
    for (int o = 0; o < int'(NO); o++) p += sq[o].size();
    return p;
  endfunction

  task automatic drain();
    int n = 0;
    while (pending() != 0 && n < 100) begin
      @(negedge clk_i); #1;
      n++;
    end
    check("drain", 64'(pending()), 64'(0));
  endtask

  // Master/slave models: drive after posedge, observe at negedge
  always begin
    @(posedge clk_i); #1;
    cyc++;
    if (!rst_ni) begin
      for (int i = 0; i < int'(NI); i++) begin
        left[i] = 0; got_gnt[i] = 1'b0; exp_q[i].delete();
      end
      for (int o = 0; o < int'(NO); o++) sq[o].delete();
    end
    out_rvalid_i = '0; out_rdata_i = '0; out_ropc_i = '0; out_rid_i = '0;
    for (int o = 0; o < int'(NO); o++) begin
      if (sq[o].size() != 0 && sq[o][0].due <= cyc) begin
        ent = sq[o].pop_front();
        out_rvalid_i[o] = 1'b1;
        out_rdata_i[o*DW +: DW] = ent.rsp[DW:1];
        out_ropc_i[o] = ent.rsp[0];
        out_rid_i[o*IW +: IW] = ent.id;
      end
    end
    if (force_bad) begin
      out_rvalid_i[0] = 1'b1;
      out_rid_i[0 +: IW] = IW'(3);
      out_rdata_i[0 +: DW] = '1;
      force_bad = 1'b0;
    end
    for (int i = 0; i < int'(NI); i++) begin
      if (got_gnt[i]) begin
        got_gnt[i] = 1'b0; left[i]--; seq[i]++;
      end
      in_req_i[i] = (left[i] > 0);
      in_sel_i[i*SW +: SW] = SW'(msel[i]);
      in_addr_i[i*AW +: AW] = mk_addr(i, msel[i], seq[i]);
      in_wdata_i[i*DW +: DW] = ~mk_addr(i, msel[i], seq[i]);
    end
    in_rready_i = rready_cfg;
    @(negedge clk_i);
    for (int o = 0; o < int'(NO); o++) begin
      if (out_req_o[o] && out_gnt_i[o])
        sq[o].push_back('{due: cyc + dly[o], rsp: rsp_of(out_addr_o[o*AW +: AW]),
                          id: out_id_o[o*IW +: IW]});
    end
    for (int i = 0; i < int'(NI); i++) begin
      if (in_gnt_o[i]) begin
        got_gnt[i] = 1'b1;
        exp_q[i].push_back(rsp_of(mk_addr(i, msel[i], seq[i])));
        check("out_id", 64'(out_id_o[msel[i]*IW +: IW]), 64'(i));
        check("out_addr", 64'(out_addr_o[msel[i]*AW +: AW]), 64'(mk_addr(i, msel[i], seq[i])));
      end
      if (in_rvalid_o[i] && in_rready_i[i]) begin
        if (exp_q[i].size() == 0) check("rsp_unexp", 64'(in_rvalid_o[i]), 64'(0));
        else check("rsp_data", 64'({in_rdata_o[i*DW +: DW], in_ropc_o[i]}), 64'(exp_q[i].pop_front()));
      end
    end
  end

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0; force_bad = 1'b0;
    rst_ni = 1'b0; rready_cfg = '0; out_gnt_i = '1;
    in_req_i = '0; in_sel_i = '0; in_addr_i = '0; in_wdata_i = '0;
    in_wen_i = '1; in_be_i = '1; in_rready_i = '0;
    out_rvalid_i = '0; out_rdata_i = '0; out_ropc_i = '0; out_rid_i = '0;
    for (int i = 0; i < int'(NI); i++) begin
      left[i] = 0; seq[i] = 0; msel[i] = 0; got_gnt[i] = 1'b0;
    end
    for (int o = 0; o < int'(NO); o++) dly[o] = 1;
    repeat (2) @(negedge clk_i);
    #1 rst_ni = 1'b1;
    @(negedge clk_i);
    check("rst_req", 64'(out_req_o), 64'(0));
    check("rst_gnt", 64'(in_gnt_o), 64'(0));
    check("rst_rvalid", 64'(in_rvalid_o), 64'(0));
    check("rst_err", 64'(err_o), 64'(0));
    #1;

    // all inputs hammer output 2: strict rotation
    rready_cfg = '1;
    for (int i = 0; i < int'(NI); i++) begin left[i] = 6; msel[i] = 2; end
    for (int k = 0; k < 18; k++) begin
      @(negedge clk_i);
      check("t1_rr", 64'(in_gnt_o), 64'(1 << (k % 3)));
    end
    #1 drain();

    // input 0 stalled by credits while its FIFO is blocked
    rready_cfg = 3'b110; msel[0] = 1; left[0] = 3;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      check("t2_gnt", 64'(in_gnt_o), (k < 2) ? 64'(1) : 64'(0));
    end
    check("t2_rvalid", 64'(in_rvalid_o[0]), 64'(1));
    #1 rready_cfg = 3'b111;
    @(negedge clk_i); check("t2_gnt_pop", 64'(in_gnt_o), 64'(0));
    @(negedge clk_i); check("t2_gnt_after", 64'(in_gnt_o), 64'(1));
    #1 drain();

    // input 1 may not switch target while a response is pending
    rready_cfg = 3'b101; msel[1] = 0; left[1] = 1;
    @(negedge clk_i); check("t3_gnt0", 64'(in_gnt_o), 64'(2));
    @(negedge clk_i); check("t3_idle", 64'(in_gnt_o), 64'(0));
    #1 msel[1] = 3; left[1] = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i); check("t3_hold", 64'(in_gnt_o), 64'(0));
    end
    check("t3_rvalid", 64'(in_rvalid_o[1]), 64'(1));
    #1 rready_cfg = 3'b111;
    @(negedge clk_i); check("t3_gnt_pop", 64'(in_gnt_o), 64'(0));
    @(negedge clk_i); check("t3_gnt3", 64'(in_gnt_o), 64'(2));
    #1 drain();

    // slow slave 3 alongside fast slave 0: per-input data stays in order
    dly[3] = 5; msel[0] = 3; left[0] = 3;
    msel[1] = 0; left[1] = 4; msel[2] = 0; left[2] = 4;
    drain();
    dly[3] = 1;

    // illegal rid: dropped, sticky error
    force_bad = 1'b1;
    @(negedge clk_i);
    check("t5_err_pre", 64'(err_o), 64'(0));
    @(negedge clk_i);
    check("t5_err_set", 64'(err_o), 64'(1));
    check("t5_no_push", 64'(in_rvalid_o), 64'(0));
    repeat (5) @(negedge clk_i);
    check("t5_err_hold", 64'(err_o), 64'(1));
    #1;

    // fill input 1 (cnt=2, FIFO full), then reset mid-flight
    rready_cfg = 3'b101; msel[1] = 1; left[1] = 2;
    repeat (5) @(negedge clk_i);
    check("t6_full", 64'(in_rvalid_o[1]), 64'(1));
    #1 rst_ni = 1'b0;
    @(negedge clk_i);
    check("t6_rst_rvalid", 64'(in_rvalid_o), 64'(0));
    check("t6_rst_err", 64'(err_o), 64'(0));
    #1 rst_ni = 1'b1; rready_cfg = '1;
    for (int i = 0; i < int'(NI); i++) begin left[i] = 1; msel[i] = 1; end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      check("t6_rr", 64'(in_gnt_o), 64'(1 << k));
    end
    #1 drain();
    check("final_err", 64'(err_o), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
